// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: byte FIFO in front of an 8N1 serialiser paced by a 16x baud strobe.
// Each bit is held for 16 strobes; frames run back-to-back while the FIFO has data.
module uart_tx_ctrl #(
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_16_x_baud,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 write_buffer,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 buffer_empty,
  output logic                 buffer_half_full,
  output logic                 buffer_full
);

  localparam int unsigned DEPTH  = 2 ** FIFO_AW;
  localparam int unsigned CNT_W  = FIFO_AW + 1;
  localparam int unsigned IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned TICK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic                 empty_q, empty_d;
  logic                 half_q, half_d;
  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic                 push_c;
  logic                 pop_c;
  logic                 bit_end_c;

  // Frame sequencing; a pop loads the FIFO head into the shift register.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    pop_c     = 1'b0;
    bit_end_c = en_16_x_baud && (tick_q == TICK_W'(15));
    if (en_16_x_baud) begin
      tick_d = tick_q + TICK_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (en_16_x_baud && !empty_q) begin
          pop_c   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tick_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          if (!empty_q) begin
            pop_c   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tick_d  = '0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level and busy follow the state being entered, so they change on the same edge.
  always_comb begin
    serial_d = 1'b1;
    busy_d   = (state_d != ST_IDLE);
    case (state_d)
      ST_START: serial_d = 1'b0;
      ST_DATA:  serial_d = shift_d[idx_d];
      default:  serial_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping; writes are gated by the registered full flag.
  always_comb begin
    push_c   = write_buffer && !full_q;
    wr_ptr_d = push_c ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CNT_W'(1);
    end
    empty_d = (count_d == CNT_W'(0));
    half_d  = (count_d >= CNT_W'(DEPTH / 2));
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      empty_q  <= 1'b1;
      half_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      empty_q  <= empty_d;
      half_q   <= half_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign serial_out       = serial_q;
  assign tx_busy          = busy_q;
  assign buffer_empty     = empty_q;
  assign buffer_half_full = half_q;
  assign buffer_full      = full_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed scenarios plus random bursts, checked by a strobe-sampled
// line decoder against a queue of bytes the bench expects to see transmitted.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_16_x_baud;
  logic [7:0] data_in;
  logic       write_buffer;
  logic       serial_out;
  logic       tx_busy;
  logic       buffer_empty;
  logic       buffer_half_full;
  logic       buffer_full;

  int         n_checks = 0;
  int         n_fail = 0;
  int         strobe_period = 0;
  logic       manual_en = 1'b0;
  int         frames = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         gap_q[$];

  always #5 clk = ~clk;

  uart_tx_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .en_16_x_baud     (en_16_x_baud),
    .data_in          (data_in),
    .write_buffer     (write_buffer),
    .serial_out       (serial_out),
    .tx_busy          (tx_busy),
    .buffer_empty     (buffer_empty),
    .buffer_half_full (buffer_half_full),
    .buffer_full      (buffer_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe source: periodic when strobe_period>0, otherwise mirrors manual_en.
  initial begin
    int cnt;
    cnt = 0;
    en_16_x_baud = 1'b0;
    forever begin
      @(negedge clk);
      if (strobe_period == 0) begin
        en_16_x_baud = manual_en;
        cnt = 0;
      end else if (cnt >= strobe_period - 1) begin
        en_16_x_baud = 1'b1;
        cnt = 0;
      end else begin
        en_16_x_baud = 1'b0;
        cnt++;
      end
    end
  end

  // Receiver model: one line sample per strobe, 16 samples per bit, 10 bits per frame.
  initial begin
    bit         in_frame;
    bit         steady;
    int         nsamp;
    int         idle_run;
    logic       cur;
    logic       s;
    logic       rs;
    logic [9:0] bits;
    in_frame = 0; steady = 0; nsamp = 0; idle_run = 0; cur = 1'b1; bits = '0;
    forever begin
      @(posedge clk);
      s  = en_16_x_baud;
      rs = reset;
      #1;
      if (rs !== 1'b1) begin
        in_frame = 0;
        idle_run = 0;
      end else if (s === 1'b1) begin
        if (!in_frame) begin
          if (serial_out === 1'b0) begin
            in_frame = 1;
            nsamp = 0;
            gap_q.push_back(idle_run);
            idle_run = 0;
          end else begin
            idle_run++;
          end
        end
        if (in_frame) begin
          if (nsamp % 16 == 0) begin
            cur = serial_out;
            steady = 1;
          end else if (serial_out !== cur) begin
            steady = 0;
          end
          if (nsamp % 16 == 15) begin
            chk("bit_steady_16_strobes", 32'(steady), 32'd1);
            bits[nsamp / 16] = cur;
          end
          nsamp++;
          if (nsamp == 160) begin
            chk("stop_bit_high", 32'(bits[9]), 32'd1);
            rx_q.push_back(bits[8:1]);
            frames++;
            in_frame = 0;
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    data_in = b;
    write_buffer = 1'b1;
    tick();
    write_buffer = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    rx_q.delete();
    exp_q.delete();
    gap_q.delete();
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int t;
    t = 0;
    while (frames < target && t < budget) begin
      tick();
      t++;
    end
    chk(tag, 32'(frames >= target), 32'd1);
  endtask

  task automatic wait_start(input string tag, input int budget, output int t);
    t = 0;
    while (serial_out !== 1'b0 && t < budget) begin
      tick();
      t++;
    end
    chk(tag, 32'(serial_out), 32'd0);
  endtask

  task automatic check_rx(input string tag);
    int n;
    chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         t;
    int         base;
    int         n;
    logic [7:0] b;
    logic [9:0] pat;

    reset = 1'b0;
    write_buffer = 1'b1;
    data_in = 8'h5A;

    // Reset held with writes and strobes active: nothing may be queued.
    strobe_period = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst%0d_serial", i), 32'(serial_out), 32'd1);
      chk($sformatf("rst%0d_empty", i), 32'(buffer_empty), 32'd1);
      chk($sformatf("rst%0d_busy", i), 32'(tx_busy), 32'd0);
      chk($sformatf("rst%0d_half", i), 32'(buffer_half_full), 32'd0);
      chk($sformatf("rst%0d_full", i), 32'(buffer_full), 32'd0);
    end
    reset = 1'b1;
    write_buffer = 1'b0;
    tick();
    chk("rst_release_empty", 32'(buffer_empty), 32'd1);
    tick(50);
    chk("rst_no_frame", 32'(frames), 32'd0);
    chk("rst_idle_line", 32'(serial_out), 32'd1);

    // Single byte 0xA5 with a strobe every 27 clocks: every bit 432 clocks.
    strobe_period = 27;
    tick(3);
    write_byte(8'hA5);
    exp_q.push_back(8'hA5);
    wait_start("a5_start_seen", 100, t);
    chk("a5_latency_in_range", 32'(t >= 1 && t <= 27), 32'd1);
    chk("a5_empty_after_pop", 32'(buffer_empty), 32'd1);
    chk("a5_busy_at_start", 32'(tx_busy), 32'd1);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a5_bit%0d_first_clk", i), 32'(serial_out), 32'(pat[i]));
      tick(431);
      chk($sformatf("a5_bit%0d_last_clk", i), 32'(serial_out), 32'(pat[i]));
      tick();
    end
    chk("a5_busy_before_fall", 32'(1'b0), 32'(1'b0) ^ 32'(tx_busy));
    chk("a5_line_idle", 32'(serial_out), 32'd1);
    chk("a5_empty_end", 32'(buffer_empty), 32'd1);
    tick(30);
    check_rx("a5_rx");

    // Back-to-back frames must abut with no idle strobes.
    strobe_period = 3;
    base = frames;
    write_byte(8'h00); exp_q.push_back(8'h00);
    write_byte(8'hFF); exp_q.push_back(8'hFF);
    write_byte(8'h55); exp_q.push_back(8'h55);
    wait_frames("b2b_frames_done", base + 3, 3 * 160 * 3 + 300);
    chk("b2b_gap_q_size", 32'(gap_q.size() >= 3), 32'd1);
    if (gap_q.size() >= 3) begin
      chk("b2b_gap_1_2", 32'(gap_q[gap_q.size() - 2]), 32'd0);
      chk("b2b_gap_2_3", 32'(gap_q[gap_q.size() - 1]), 32'd0);
    end
    check_rx("b2b_rx");

    // Fill with strobes stopped; 17th byte is dropped.
    strobe_period = 0;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      write_byte(8'(k));
      n = (k + 1 > 16) ? 16 : k + 1;
      if (k < 16) exp_q.push_back(8'(k));
      chk($sformatf("fill%0d_empty", k), 32'(buffer_empty), 32'd0);
      chk($sformatf("fill%0d_half", k), 32'(buffer_half_full), 32'(n >= 8));
      chk($sformatf("fill%0d_full", k), 32'(buffer_full), 32'(n == 16));
    end
    strobe_period = 1;
    base = frames;
    wait_frames("fill_frames_done", base + 16, 16 * 160 + 200);
    chk("fill_empty_end", 32'(buffer_empty), 32'd1);
    check_rx("fill_rx");

    // Full FIFO: pop and write on one edge -> write dropped, count 15.
    strobe_period = 0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      write_byte(b);
      exp_q.push_back(b);
    end
    chk("sim_full_before", 32'(buffer_full), 32'd1);
    manual_en = 1'b1;
    data_in = 8'hEE;
    write_buffer = 1'b1;
    tick();
    manual_en = 1'b0;
    write_buffer = 1'b0;
    chk("sim_full_after_pop", 32'(buffer_full), 32'd0);
    chk("sim_half_after_pop", 32'(buffer_half_full), 32'd1);
    chk("sim_busy_after_pop", 32'(tx_busy), 32'd1);
    chk("sim_line_start", 32'(serial_out), 32'd0);
    tick(2);
    write_byte(8'h77);
    exp_q.push_back(8'h77);
    chk("sim_full_refill", 32'(buffer_full), 32'd1);
    write_byte(8'h66);
    chk("sim_full_hold", 32'(buffer_full), 32'd1);
    strobe_period = 1;
    base = frames;
    wait_frames("sim_frames_done", base + 17, 17 * 160 + 200);
    check_rx("sim_full_rx");

    // Count 3: pop and write on one edge keep order and count.
    strobe_period = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      write_byte(b);
      exp_q.push_back(b);
    end
    manual_en = 1'b1;
    data_in = 8'h44;
    write_buffer = 1'b1;
    tick();
    manual_en = 1'b0;
    write_buffer = 1'b0;
    exp_q.push_back(8'h44);
    chk("sim3_empty", 32'(buffer_empty), 32'd0);
    chk("sim3_half", 32'(buffer_half_full), 32'd0);
    chk("sim3_busy", 32'(tx_busy), 32'd1);
    strobe_period = 1;
    base = frames;
    wait_frames("sim3_frames_done", base + 4, 4 * 160 + 200);
    check_rx("sim3_rx");

    // Reset during data bit 4 of 0x3C abandons the frame and the queued byte.
    do_reset();
    strobe_period = 1;
    write_byte(8'h3C);
    write_byte(8'h99);
    wait_start("midrst_start_seen", 40, t);
    tick(16 * 5 + 8);
    chk("midrst_busy_in_bit4", 32'(tx_busy), 32'd1);
    chk("midrst_line_bit4", 32'(serial_out), 32'd1);
    reset = 1'b0;
    tick();
    chk("midrst_line", 32'(serial_out), 32'd1);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    chk("midrst_empty", 32'(buffer_empty), 32'd1);
    reset = 1'b1;
    base = frames;
    tick(500);
    chk("midrst_no_more_frames", 32'(frames), 32'(base));
    chk("midrst_line_idle", 32'(serial_out), 32'd1);
    chk("midrst_rx_empty", 32'(rx_q.size()), 32'd0);

    // Random bursts (at most 16 bytes each, so never full) at random strobe rates.
    rx_q.delete();
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      strobe_period = $urandom_range(1, 4);
      n = $urandom_range(1, 16);
      base = frames;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        write_byte(b);
        exp_q.push_back(b);
        tick($urandom_range(0, 5));
      end
      wait_frames($sformatf("rand%0d_frames_done", r), base + n, n * 160 * 4 + 500);
      check_rx($sformatf("rand%0d_rx", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
